// File: rtl/sc_spi_clkgen_if.sv
// Bundle carrying the configuration, burst control and clock/strobe outputs of sc_spi_clkgen.
// The HOLD signal exists only when SC_SPI_CLKGEN_HOLD_EN is defined.
interface sc_spi_clkgen_if #(
  parameter int CNT_W    = 8,
  parameter int BITCNT_W = 6
);
  logic [CNT_W-1:0]    CLK_WIDTH_HIGH;
  logic [CNT_W-1:0]    CLK_WIDTH_LOW;
  logic [1:0]          CLK_MODE;
  logic [BITCNT_W-1:0] CYCLES;
  logic                START;
  logic                STOP;
`ifdef SC_SPI_CLKGEN_HOLD_EN
  logic                HOLD;
`endif
  logic                SPICLK;
  logic                BUSY;
  logic                DONE;
  logic                SAMPLE_STB;
  logic                SHIFT_STB;

  modport master (
`ifdef SC_SPI_CLKGEN_HOLD_EN
    output HOLD,
`endif
    output CLK_WIDTH_HIGH, CLK_WIDTH_LOW, CLK_MODE, CYCLES, START, STOP,
    input  SPICLK, BUSY, DONE, SAMPLE_STB, SHIFT_STB
  );

  modport slave (
`ifdef SC_SPI_CLKGEN_HOLD_EN
    input  HOLD,
`endif
    input  CLK_WIDTH_HIGH, CLK_WIDTH_LOW, CLK_MODE, CYCLES, START, STOP,
    output SPICLK, BUSY, DONE, SAMPLE_STB, SHIFT_STB
  );
endinterface

// File: rtl/sc_spi_clkgen.sv
// Burst SPI clock generator: programmable phase widths, period count and CPOL/CPHA mode.
// Define SC_SPI_CLKGEN_HOLD_EN to add HOLD, which stretches the last cycle of each idle phase.
//
// state   | meaning
// IDLE    | no burst; SPICLK follows CPOL, START accepted here
// SETUP   | SPICLK = CPOL for W_LOW cycles before the first edge
// ACT     | SPICLK = ~CPOL for W_HIGH cycles (entry = leading edge)
// IDL     | SPICLK = CPOL for W_LOW cycles (entry = trailing edge)
module sc_spi_clkgen #(
  parameter int CNT_W    = 8,
  parameter int BITCNT_W = 6
) (
  input  logic            SRCCLK,
  input  logic            SYSRST,
  sc_spi_clkgen_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACT, S_IDL} state_t;

  state_t              state;
  logic [CNT_W-1:0]    phase_cnt;
  logic [CNT_W-1:0]    w_high;
  logic [CNT_W-1:0]    w_low;
  logic [BITCNT_W:0]   per_cnt;
  logic                cpol;
  logic                cpha;
  logic                spiclk;
  logic                busy;
  logic                done;
  logic                sample_stb;
  logic                shift_stb;
  logic                hold;
  logic [CNT_W-1:0]    w_high_in;
  logic [CNT_W-1:0]    w_low_in;
  logic [BITCNT_W:0]   cycles_in;

`ifdef SC_SPI_CLKGEN_HOLD_EN
  assign hold = bus.HOLD;
`else
  assign hold = 1'b0;
`endif

  // Zero widths and a zero period count are mapped to their usable meanings at accept time.
  always_comb begin
    w_high_in = (bus.CLK_WIDTH_HIGH == '0) ? CNT_W'(1) : bus.CLK_WIDTH_HIGH;
    w_low_in  = (bus.CLK_WIDTH_LOW  == '0) ? CNT_W'(1) : bus.CLK_WIDTH_LOW;
    cycles_in = (bus.CYCLES == '0) ? {1'b1, {BITCNT_W{1'b0}}} : {1'b0, bus.CYCLES};
  end

  always_ff @(posedge SRCCLK or posedge SYSRST) begin
    if (SYSRST) begin
      state      <= S_IDLE;
      phase_cnt  <= '0;
      per_cnt    <= '0;
      w_high     <= '0;
      w_low      <= '0;
      cpol       <= 1'b0;
      cpha       <= 1'b0;
      spiclk     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sample_stb <= 1'b0;
      shift_stb  <= 1'b0;
    end else begin
      done       <= 1'b0;
      sample_stb <= 1'b0;
      shift_stb  <= 1'b0;
      if (state != S_IDLE && bus.STOP) begin
        state  <= S_IDLE;
        busy   <= 1'b0;
        spiclk <= cpol;
      end else begin
        case (state)
          S_IDLE: begin
            spiclk <= bus.CLK_MODE[1];
            if (bus.START && !bus.STOP) begin
              w_high    <= w_high_in;
              w_low     <= w_low_in;
              cpol      <= bus.CLK_MODE[1];
              cpha      <= bus.CLK_MODE[0];
              per_cnt   <= cycles_in;
              phase_cnt <= w_low_in - CNT_W'(1);
              busy      <= 1'b1;
              state     <= S_SETUP;
            end
          end
          S_SETUP: begin
            if (phase_cnt == '0) begin
              state      <= S_ACT;
              spiclk     <= ~cpol;
              phase_cnt  <= w_high - CNT_W'(1);
              sample_stb <= ~cpha;
              shift_stb  <= cpha;
            end else begin
              phase_cnt <= phase_cnt - CNT_W'(1);
            end
          end
          S_ACT: begin
            if (phase_cnt == '0) begin
              state      <= S_IDL;
              spiclk     <= cpol;
              phase_cnt  <= w_low - CNT_W'(1);
              sample_stb <= cpha;
              // In mode CPHA=0 the final trailing edge has no following bit to shift out.
              shift_stb  <= ~cpha && (per_cnt != (BITCNT_W+1)'(1));
            end else begin
              phase_cnt <= phase_cnt - CNT_W'(1);
            end
          end
          S_IDL: begin
            if (phase_cnt != '0) begin
              phase_cnt <= phase_cnt - CNT_W'(1);
            end else if (!hold) begin
              per_cnt <= per_cnt - (BITCNT_W+1)'(1);
              if (per_cnt == (BITCNT_W+1)'(1)) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state      <= S_ACT;
                spiclk     <= ~cpol;
                phase_cnt  <= w_high - CNT_W'(1);
                sample_stb <= ~cpha;
                shift_stb  <= cpha;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.SPICLK     = spiclk;
  assign bus.BUSY       = busy;
  assign bus.DONE       = done;
  assign bus.SAMPLE_STB = sample_stb;
  assign bus.SHIFT_STB  = shift_stb;

endmodule

// File: tb/tb_sc_spi_clkgen.sv
// Scoreboard bench for sc_spi_clkgen: stimulus pushes expected edge/DONE events, a monitor pops them.
module tb_sc_spi_clkgen;
  localparam int BIG = 32'h7fff_ffff;

  logic SRCCLK = 1'b0;
  logic SYSRST = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  sc_spi_clkgen_if #(.CNT_W(8), .BITCNT_W(6)) bus ();
  sc_spi_clkgen #(.CNT_W(8), .BITCNT_W(6)) dut (.SRCCLK(SRCCLK), .SYSRST(SYSRST), .bus(bus));

  always #5 SRCCLK = ~SRCCLK;
  always @(posedge SRCCLK) cyc <= cyc + 1;

  typedef struct {
    int   c;
    logic clk;
    logic smp;
    logic shf;
    logic dn;
  } ev_t;
  ev_t q[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_ev(int c, logic k, logic s, logic h, logic d, int cutoff);
    ev_t e;
    if (c <= cutoff) begin
      e.c = c; e.clk = k; e.smp = s; e.shf = h; e.dn = d;
      q.push_back(e);
    end
  endfunction

  // Timeline model: returns the cycle of the DONE pulse.
  function automatic int model(int n, int wh_raw, int wl_raw, int mode, int ncyc_raw,
                               int cutoff, int hold_p, int hold_len);
    logic [1:0] m;
    logic cpol, cpha;
    int wh, wl, ncyc, t;
    m    = 2'(mode);
    cpol = m[1];
    cpha = m[0];
    wh   = (wh_raw == 0) ? 1 : wh_raw;
    wl   = (wl_raw == 0) ? 1 : wl_raw;
    ncyc = (ncyc_raw == 0) ? 64 : ncyc_raw;
    t    = n + 1 + wl;
    for (int p = 1; p <= ncyc; p++) begin
      push_ev(t, ~cpol, ~cpha, cpha, 1'b0, cutoff);
      if (cpha || p < ncyc) push_ev(t + wh, cpol, cpha, ~cpha, 1'b0, cutoff);
      t += wh + wl;
      if (p == hold_p) t += hold_len;
    end
    push_ev(t, cpol, 1'b0, 1'b0, 1'b1, cutoff);
    return t;
  endfunction

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge SRCCLK);
  endtask

  task automatic start_burst(input int at, input int wh, input int wl, input int mode,
                             input int ncyc, input int cutoff, input int hold_p,
                             input int hold_len, output int n, output int fin);
    wait_cyc(at);
    bus.CLK_WIDTH_HIGH = 8'(wh);
    bus.CLK_WIDTH_LOW  = 8'(wl);
    bus.CLK_MODE       = 2'(mode);
    bus.CYCLES         = 6'(ncyc);
    bus.START          = 1'b1;
    n   = cyc;
    fin = model(n, wh, wl, mode, ncyc, cutoff, hold_p, hold_len);
    @(negedge SRCCLK);
    bus.START = 1'b0;
  endtask

  // Monitor: every strobe or DONE must match the next expected event.
  always @(negedge SRCCLK) begin
    ev_t e;
    if (!SYSRST && (bus.DONE || bus.SAMPLE_STB || bus.SHIFT_STB)) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event cycle=%0d clk=%b smp=%b shf=%b done=%b, required none",
                 cyc, bus.SPICLK, bus.SAMPLE_STB, bus.SHIFT_STB, bus.DONE);
      end else begin
        e = q.pop_front();
        if (e.c != cyc || e.clk != bus.SPICLK || e.smp != bus.SAMPLE_STB ||
            e.shf != bus.SHIFT_STB || e.dn != bus.DONE) begin
          fails++;
          $display("FAIL event: actual cycle=%0d clk=%b smp=%b shf=%b done=%b, required cycle=%0d clk=%b smp=%b shf=%b done=%b",
                   cyc, bus.SPICLK, bus.SAMPLE_STB, bus.SHIFT_STB, bus.DONE,
                   e.c, e.clk, e.smp, e.shf, e.dn);
        end
      end
    end
  end

  initial begin
    int n, fin, at;
    bus.CLK_WIDTH_HIGH = 8'd2;
    bus.CLK_WIDTH_LOW  = 8'd2;
    bus.CLK_MODE       = 2'b10;
    bus.CYCLES         = 6'd8;
    bus.START          = 1'b0;
    bus.STOP           = 1'b0;
`ifdef SC_SPI_CLKGEN_HOLD_EN
    bus.HOLD           = 1'b0;
`endif

    // Reset state
    repeat (3) @(negedge SRCCLK);
    check("rst_spiclk", bus.SPICLK, 0);
    check("rst_busy", bus.BUSY, 0);
    check("rst_done", bus.DONE, 0);
    check("rst_sample", bus.SAMPLE_STB, 0);
    check("rst_shift", bus.SHIFT_STB, 0);
    SYSRST = 1'b0;
    @(negedge SRCCLK);
    check("idle_spiclk_cpol1", bus.SPICLK, 1);
    bus.CLK_MODE = 2'b00;
    @(negedge SRCCLK);
    check("idle_spiclk_cpol0", bus.SPICLK, 0);

    // Mode 0, 2/2, 8 periods; START while busy and width change are ignored
    check("busy_idle", bus.BUSY, 0);
    start_burst(cyc + 2, 2, 2, 0, 8, BIG, 0, 0, n, fin);
    check("busy_after_start", bus.BUSY, 1);
    wait_cyc(n + 5);
    bus.CYCLES = 6'd3;
    bus.START  = 1'b1;
    @(negedge SRCCLK);
    bus.START  = 1'b0;
    wait_cyc(n + 7);
    bus.CLK_WIDTH_HIGH = 8'd5;
    wait_cyc(fin - 1);
    check("busy_before_done", bus.BUSY, 1);
    wait_cyc(fin);
    check("busy_clear_at_done", bus.BUSY, 0);

    // Back-to-back burst accepted in the DONE cycle, mode 1, high width now 5
    start_burst(fin, 5, 1, 1, 3, BIG, 0, 0, n, fin);
    check("busy_back_to_back", bus.BUSY, 1);
    wait_cyc(fin);
    check("busy_end_mode1", bus.BUSY, 0);

    // Mode 3, zero widths and zero count -> 64 periods of 1/1
    start_burst(cyc + 3, 0, 0, 3, 0, BIG, 0, 0, n, fin);
    wait_cyc(n + 2);
    check("mode3_first_leading", bus.SPICLK, 0);
    wait_cyc(fin - 1);
    check("mode3_busy_last", bus.BUSY, 1);
    wait_cyc(fin);
    check("mode3_busy_end", bus.BUSY, 0);
    check("mode3_idle_level", bus.SPICLK, 1);

    // STOP in second ACT cycle of period 3
    at = cyc + 2;
    start_burst(at, 2, 2, 0, 8, at + 12, 0, 0, n, fin);
    wait_cyc(n + 12);
    check("stop_in_act_level", bus.SPICLK, 1);
    bus.STOP = 1'b1;
    @(negedge SRCCLK);
    bus.STOP = 1'b0;
    check("stop_spiclk", bus.SPICLK, 0);
    check("stop_busy", bus.BUSY, 0);
    repeat (3) @(negedge SRCCLK);
    check("stop_stays_idle", bus.BUSY, 0);
    start_burst(cyc + 2, 3, 1, 2, 2, BIG, 0, 0, n, fin);
    check("restart_busy", bus.BUSY, 1);
    wait_cyc(fin);
    check("restart_end", bus.BUSY, 0);

    // START and STOP together in IDLE
    @(negedge SRCCLK);
    bus.START = 1'b1;
    bus.STOP  = 1'b1;
    @(negedge SRCCLK);
    bus.START = 1'b0;
    bus.STOP  = 1'b0;
    check("start_stop_busy", bus.BUSY, 0);
    repeat (4) @(negedge SRCCLK);
    check("start_stop_still_idle", bus.BUSY, 0);

    // Asynchronous reset mid-burst while SPICLK sits at CPOL=1
    at = cyc + 2;
    start_burst(at, 1, 2, 3, 5, at + 5, 0, 0, n, fin);
    wait_cyc(n + 5);
    check("pre_reset_spiclk", bus.SPICLK, 1);
    check("pre_reset_busy", bus.BUSY, 1);
    #1 SYSRST = 1'b1;
    #1;
    check("async_rst_spiclk", bus.SPICLK, 0);
    check("async_rst_busy", bus.BUSY, 0);
    check("async_rst_strobes", {bus.SAMPLE_STB, bus.SHIFT_STB, bus.DONE}, 0);
    @(negedge SRCCLK);
    SYSRST = 1'b0;
    repeat (2) @(negedge SRCCLK);

`ifdef SC_SPI_CLKGEN_HOLD_EN
    // HOLD for 6 cycles at the end of IDL in period 2
    start_burst(cyc + 2, 2, 2, 0, 4, BIG, 2, 6, n, fin);
    wait_cyc(n + 10);
    bus.HOLD = 1'b1;
    wait_cyc(n + 16);
    bus.HOLD = 1'b0;
    check("hold_level", bus.SPICLK, 0);
    wait_cyc(fin);
    check("hold_end", bus.BUSY, 0);
`endif

    repeat (5) @(negedge SRCCLK);
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
